// File: rtl/bp_cfg_link_sequencer.sv
// Boot-time configuration sequencer: freeze, core IDs, CCE ucode load, CCE mode, unfreeze.
// Writes leave over a valid/ready link throttled by a credit count of unacked writes.
module bp_cfg_link_sequencer #(
   parameter int num_core_p        = 1,
   parameter int cce_pc_width_p    = 8,
   parameter int cfg_addr_width_p  = 16,
   parameter int cfg_data_width_p  = 64,
   parameter int max_outstanding_p = 4,
   parameter int cce_mode_p        = 1,
   localparam int dst_width_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic                        ucode_v_o,
   output logic [cce_pc_width_p-1:0]   ucode_addr_o,
   input  logic [cfg_data_width_p-1:0] ucode_data_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [dst_width_lp-1:0]     cfg_dst_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_ack_v_i,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

   typedef enum logic [3:0] {
      S_FREEZE, S_ID, S_UC_RD, S_UC_WR, S_MODE, S_DRAIN0, S_UNFRZ, S_DRAIN1, S_DONE
   } state_e;

   state_e                        state;
   logic [dst_width_lp-1:0]       dst;
   logic [cce_pc_width_p-1:0]     pc;
   logic [cnt_width_lp-1:0]       count;
   logic [cfg_data_width_p-1:0]   data_r;
   logic                          have_data;
   logic                          live;
   logic                          err_r;

   logic                          wr_state;
   logic [cfg_addr_width_p-1:0]   wr_addr;
   logic [cfg_data_width_p-1:0]   wr_data;
   logic                          xfer;
   logic                          spur;
   logic                          last_dst;

   // live masks the first cycle out of reset so every output reads 0 while reset is seen
   always_comb begin
      wr_state = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      case (state)
         S_FREEZE: begin
            wr_state = 1'b1;
            wr_addr  = cfg_addr_width_p'(16'h0002);
            wr_data  = cfg_data_width_p'(1);
         end
         S_ID: begin
            wr_state = 1'b1;
            wr_addr  = cfg_addr_width_p'(16'h0004);
            wr_data  = cfg_data_width_p'(dst);
         end
         S_UC_WR: begin
            wr_state = have_data;
            wr_addr  = cfg_addr_width_p'(16'h8000) + cfg_addr_width_p'(pc);
            wr_data  = data_r;
         end
         S_MODE: begin
            wr_state = 1'b1;
            wr_addr  = cfg_addr_width_p'(16'h0006);
            wr_data  = cfg_data_width_p'(cce_mode_p);
         end
         S_UNFRZ: begin
            wr_state = 1'b1;
            wr_addr  = cfg_addr_width_p'(16'h0002);
            wr_data  = '0;
         end
         default: ;
      endcase
   end

   assign cfg_v_o      = live & wr_state & (count < cnt_width_lp'(max_outstanding_p));
   assign cfg_dst_o    = (live & wr_state) ? dst : '0;
   assign cfg_addr_o   = (live & wr_state) ? wr_addr : '0;
   assign cfg_data_o   = (live & wr_state) ? wr_data : '0;
   assign ucode_v_o    = live & (state == S_UC_RD);
   assign ucode_addr_o = ucode_v_o ? pc : '0;
   assign done_o       = live & (state == S_DONE);
   assign err_o        = err_r;

   assign xfer     = cfg_v_o & cfg_ready_i;
   assign spur     = cfg_ack_v_i & (count == '0) & ~xfer;
   assign last_dst = (dst == dst_width_lp'(num_core_p - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= S_FREEZE;
         dst       <= '0;
         pc        <= '0;
         count     <= '0;
         data_r    <= '0;
         have_data <= 1'b0;
         live      <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         live <= 1'b1;
         if (spur) err_r <= 1'b1;
         if (xfer & ~cfg_ack_v_i)
            count <= count + cnt_width_lp'(1);
         else if (~xfer & cfg_ack_v_i & (count != '0))
            count <= count - cnt_width_lp'(1);

         case (state)
            S_FREEZE, S_ID, S_MODE, S_UNFRZ: begin
               if (xfer) begin
                  if (last_dst) begin
                     dst <= '0;
                     case (state)
                        S_FREEZE: state <= S_ID;
                        S_ID:     state <= S_UC_RD;
                        S_MODE:   state <= S_DRAIN0;
                        default:  state <= S_DRAIN1;
                     endcase
                  end else begin
                     dst <= dst + dst_width_lp'(1);
                  end
               end
            end
            S_UC_RD: begin
               state     <= S_UC_WR;
               have_data <= 1'b0;
            end
            // ucode word arrives the cycle after the read strobe; hold the write until captured
            S_UC_WR: begin
               if (!have_data) begin
                  data_r    <= ucode_data_i;
                  have_data <= 1'b1;
               end else if (xfer) begin
                  pc    <= pc + cce_pc_width_p'(1);
                  state <= S_UC_RD;
                  if (pc == '1) begin
                     if (last_dst) begin
                        dst   <= '0;
                        state <= S_MODE;
                     end else begin
                        dst <= dst + dst_width_lp'(1);
                     end
                  end
               end
            end
            S_DRAIN0: if (count == '0) begin
               state <= S_UNFRZ;
               dst   <= '0;
            end
            S_DRAIN1: if (count == '0) state <= S_DONE;
            S_DONE:   ;
            default:  state <= S_FREEZE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_cfg_link_sequencer.sv
// Scoreboarded bench: stimulus queues the expected write stream, a negedge monitor
// models the link (acks, ucode ROM) and compares each transfer as it happens.
module tb_bp_cfg_link_sequencer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        ucode_v_o;
   logic [1:0]  ucode_addr_o;
   logic [63:0] ucode_data_i;
   logic        cfg_v_o;
   logic        cfg_ready_i;
   logic [0:0]  cfg_dst_o;
   logic [15:0] cfg_addr_o;
   logic [63:0] cfg_data_o;
   logic        cfg_ack_v_i;
   logic        done_o;
   logic        err_o;

   bp_cfg_link_sequencer #(
      .num_core_p(2), .cce_pc_width_p(2), .cfg_addr_width_p(16),
      .cfg_data_width_p(64), .max_outstanding_p(4), .cce_mode_p(1)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .ucode_v_o(ucode_v_o), .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
      .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_dst_o(cfg_dst_o),
      .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ack_v_i(cfg_ack_v_i),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [0:0]  dst;
      logic [15:0] addr;
      logic [63:0] data;
      bit          drain;
   } exp_t;

   exp_t expq[$];
   int   ackq[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   sends = 0;
   int   acks_run = 0;
   int   out_m = 0;
   int   ncyc = 0;
   bit   done_seen = 0;
   bit   hold = 0;
   int   ack_dly = 1;
   int   spur_req = 0, spur_done = 0;
   int   rel_req = 0, rel_done = 0;
   int   align_req = 0, align_done = 0;

   function automatic logic [63:0] rom_word(input logic [1:0] a);
      case (a)
         2'd0: rom_word = 64'h0123_4567_89AB_CDEF;
         2'd1: rom_word = 64'hFEDC_BA98_7654_3210;
         2'd2: rom_word = 64'hA5A5_5A5A_0F0F_F0F0;
         default: rom_word = 64'h0000_0000_DEAD_BEEF;
      endcase
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_seq();
      exp_t e;
      logic [1:0] p;
      e.drain = 1'b0;
      for (int d = 0; d < 2; d++) begin
         e.dst = d[0]; e.addr = 16'h0002; e.data = 64'd1; expq.push_back(e);
      end
      for (int d = 0; d < 2; d++) begin
         e.dst = d[0]; e.addr = 16'h0004; e.data = 64'(d); expq.push_back(e);
      end
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) begin
            p = i[1:0];
            e.dst = d[0]; e.addr = 16'h8000 + 16'(i); e.data = rom_word(p); expq.push_back(e);
         end
      for (int d = 0; d < 2; d++) begin
         e.dst = d[0]; e.addr = 16'h0006; e.data = 64'd1; expq.push_back(e);
      end
      for (int d = 0; d < 2; d++) begin
         e.dst = d[0]; e.addr = 16'h0002; e.data = 64'd0; e.drain = (d == 0);
         expq.push_back(e);
      end
   endtask

   // ucode ROM: word for the strobed address is presented from the next half cycle on
   initial begin
      ucode_data_i = '0;
      forever begin
         @(negedge clk);
         if (ucode_v_o) ucode_data_i = rom_word(ucode_addr_o);
      end
   end

   // link monitor: compare transfers, track credits, return acks
   initial begin
      bit   xfer_s, ack_now, real_ack;
      exp_t e;
      cfg_ack_v_i = 1'b0;
      forever begin
         @(negedge clk);
         ack_now = 1'b0;
         real_ack = 1'b0;
         xfer_s = cfg_v_o && cfg_ready_i;
         if (reset_i) begin
            ackq.delete();
            out_m = 0; sends = 0; acks_run = 0; done_seen = 0;
            spur_done = spur_req; rel_done = rel_req; align_done = align_req;
         end else begin
            if (xfer_s) begin
               if (expq.size() == 0) begin
                  chk("unexpected_write", {cfg_dst_o, cfg_addr_o, cfg_data_o}, '0);
               end else begin
                  e = expq.pop_front();
                  chk("wr_dst", cfg_dst_o, e.dst);
                  chk("wr_addr", cfg_addr_o, e.addr);
                  chk("wr_data", cfg_data_o, e.data);
                  if (e.drain) chk("drain_credit_zero", out_m, 0);
               end
               chk("credit_limit", out_m < 4, 1);
               sends++;
               ackq.push_back(ncyc + ack_dly);
            end
            if (spur_done != spur_req) begin
               spur_done++;
               ack_now = 1'b1;
            end else if (rel_done != rel_req && ackq.size() > 0) begin
               rel_done++;
               void'(ackq.pop_front());
               real_ack = 1'b1;
            end else if (align_done != align_req && xfer_s && ackq.size() > 0) begin
               align_done++;
               void'(ackq.pop_front());
               real_ack = 1'b1;
            end else if (!hold && ackq.size() > 0 && ackq[0] <= ncyc) begin
               void'(ackq.pop_front());
               real_ack = 1'b1;
            end
            if (real_ack) begin
               ack_now = 1'b1;
               acks_run++;
               out_m--;
            end
            if (xfer_s) out_m++;
            if (done_o && !done_seen) begin
               done_seen = 1;
               chk("done_after_16_acks", acks_run, 16);
            end
         end
         cfg_ack_v_i = ack_now;
         ncyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && !done_o; i++) step();
      chk("done_reached", done_o, 1);
   endtask

   function automatic logic [127:0] outs();
      outs = {cfg_v_o, ucode_v_o, ucode_addr_o, cfg_dst_o, cfg_addr_o, cfg_data_o, done_o, err_o};
   endfunction

   initial begin
      logic [127:0] snap;
      bit found;
      reset_i = 1'b1;
      cfg_ready_i = 1'b0;
      repeat (3) step();
      chk("reset_outputs", outs(), '0);

      // run 1: full sequence, ready always, ack one cycle after each send, spurious ack first
      push_seq();
      cfg_ready_i = 1'b1; hold = 0; ack_dly = 1;
      reset_i = 1'b0;
      spur_req++;
      step();
      chk("spurious_err", err_o, 1);
      wait_done(400);
      chk("run1_sends", sends, 16);
      chk("run1_queue_empty", expq.size(), 0);
      chk("err_sticky", err_o, 1);
      reset_i = 1'b1;
      step(); step();
      chk("err_cleared_by_reset", err_o, 0);
      chk("reset_outputs_after_done", outs(), '0);

      // run 2: backpressure, credit limit, same-cycle send+ack, delayed-ack drain
      push_seq();
      cfg_ready_i = 1'b0; hold = 1; ack_dly = 20;
      reset_i = 1'b0;
      for (int i = 0; i < 20 && !cfg_v_o; i++) step();
      chk("bp_v_rise", cfg_v_o, 1);
      chk("bp_first_dst", cfg_dst_o, 0);
      chk("bp_first_addr", cfg_addr_o, 16'h0002);
      chk("bp_first_data", cfg_data_o, 64'd1);
      snap = {cfg_v_o, cfg_dst_o, cfg_addr_o, cfg_data_o};
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_stable", {cfg_v_o, cfg_dst_o, cfg_addr_o, cfg_data_o}, snap);
      end
      chk("bp_no_xfer", sends, 0);
      cfg_ready_i = 1'b1;
      step();
      chk("bp_first_ready_xfer", sends, 1);
      repeat (30) step();
      chk("credit_stop_sends", sends, 4);
      chk("credit_stop_v", cfg_v_o, 0);
      rel_req++;
      repeat (30) step();
      chk("one_ack_one_send", sends, 5);
      chk("one_ack_v_low", cfg_v_o, 0);
      rel_req++;
      align_req++;
      repeat (40) step();
      chk("send_ack_same_cycle", sends, 7);
      chk("send_ack_v_low", cfg_v_o, 0);
      hold = 0;
      wait_done(2000);
      chk("run2_sends", sends, 16);
      chk("run2_queue_empty", expq.size(), 0);
      chk("run2_no_err", err_o, 0);

      // run 3: reset while UCODE dst1 pc2 is pending
      reset_i = 1'b1;
      step(); step();
      push_seq();
      cfg_ready_i = 1'b1; hold = 0; ack_dly = 1;
      reset_i = 1'b0;
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         if (cfg_v_o && cfg_dst_o == 1'b1 && cfg_addr_o == 16'h8002) found = 1;
      end
      chk("mid_target_found", found, 1);
      cfg_ready_i = 1'b0;
      reset_i = 1'b1;
      step();
      chk("mid_reset_outputs", outs(), '0);
      expq.delete();
      step();
      push_seq();
      cfg_ready_i = 1'b1;
      reset_i = 1'b0;
      wait_done(400);
      chk("run3_sends", sends, 16);
      chk("run3_queue_empty", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
